uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Transmit side of the board UART; counterpart of the RX block. Same tick source as RX:
//  BaudRateGenerator out -> i_baud_rate, a 1-cycle pulse at 16x baud. A small FIFO
//  accepts bytes from the core, and the block serialises each one as 8N1 (8O1 with parity).
//  Line idles high and frames back-to-back while the FIFO holds data.
// PARAMETERS
//  NB_DATA    8   data bits per frame, sent LSB first
//  SB_TICK    16  baud ticks per stop bit (16 = 1 stop bit, 32 = 2)
//  FIFO_AW    2   FIFO address width; depth = 2**FIFO_AW = 4 entries
// PORTS
//  clk          in   1        system clock, all logic on posedge
//  rst          in   1        synchronous, active-low reset
//  i_baud_rate  in   1        16x-baud tick, 1 clk wide
//  i_tx_start   in   1        push i_data into FIFO this cycle
//  i_data       in   NB_DATA  byte to queue
//  o_tx         out  1        serial line (registered), idle high
//  o_tx_done    out  1        1-clk pulse on the last tick of the stop bit
//  o_busy       out  1        state != IDLE
//  o_full       out  1        FIFO holds 2**FIFO_AW entries
//  o_empty      out  1        FIFO holds 0 entries
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//  - o_tx=1, o_tx_done=0, o_busy=0, o_empty=1, o_full=0
//  - state=IDLE; tick count, bit count, wr/rd pointers cleared; FIFO contents are don't-care
//  Reset mid-frame: line returns high on that edge, queued bytes discarded, no done pulse.
//  FIFO:
//  - Push when i_tx_start && !o_full. A push while full is dropped silently.
//  - Pointers are FIFO_AW+1 bits wide; full/empty come from the MSB compare.
//  - Push and pop in the same cycle are both honoured; the count is unchanged.
//  FSM (tick count s, 0..15; bit count n):
//  - IDLE: if !o_empty, pop the head into shreg, s=0, o_tx<=0, go to START.
//    Push into an empty FIFO while IDLE gives o_tx low 2 clks after the push edge.
//  - START: on each tick s++. At tick with s==15: s=0, n=0, o_tx<=shreg[0], go to DATA.
//  - DATA: at tick with s==15: s=0, shreg>>=1.
//    - If n==NB_DATA-1: go to PARITY (feature on) or STOP.
//      o_tx<=parity or 1 respectively.
//    - Else n++ and o_tx<=next bit.
//  - STOP: o_tx=1. At tick with s==SB_TICK-1: o_tx_done<=1 for one clk, go to IDLE.
//  - Clocks without a tick hold all state. Ticks are counted only outside IDLE.
//  - Back-to-back frames: IDLE lasts exactly 1 clk between stop bit and next start bit.
//  - Frame length = (1+NB_DATA+P)*16 + SB_TICK ticks (+1 clk in IDLE), where P = 1 with parity, else 0.
//  - i_data and i_tx_start may change in any cycle. A byte already popped is unaffected by later pushes.
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//  - PARITY state is added after DATA and lasts 16 ticks.
//  - o_tx = ~^data: odd parity, so total ones including the parity bit is odd.
//  - Parity is computed at pop time from the popped byte.
//  UART_TX_PARITY_EN undefined:
//  - No PARITY state; DATA goes straight to STOP. Frames are 8N1, compatible with current RX.
// TESTING
//  1. Reset held 5 clks, then released with no push -> o_tx=1, o_empty=1, o_busy=0, no o_tx_done.
//  2. i_baud_rate every clk, push 0xA5 -> o_tx low 2 clks later.
//     Then 16-clk bits 0,1,0,1,0,0,1,0,1 (start, LSB-first data) and 16 clks high.
//     o_tx_done pulses once at the end.
//  3. i_baud_rate tied 0, push 6 bytes on consecutive clks ->
//     byte1 popped (o_busy=1), bytes 2-5 queued, o_full=1, byte6 dropped.
//     Enable ticks -> exactly 5 frames, 1 idle clk between each.
//  4. Loopback o_tx->RX i_rx with BaudRateGenerator, push 0x3C then 0xFF ->
//     RX o_data 0x3C then 0xFF, one o_rx_done each.
//  5. Assert rst during DATA bit 3 of 0x55 with 2 bytes queued ->
//     o_tx=1 next clk, o_empty=1, no o_tx_done, no further frames.
//  6. UART_TX_PARITY_EN defined, push 0x07 -> parity bit 0 between data and stop.
//     Push 0x03 -> parity bit 1.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 serial transmitter on a 16x baud tick; define UART_TX_PARITY_EN for 8O1 frames.
module uart_tx #(
  parameter int NB_DATA = 8,
  parameter int SB_TICK = 16,
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_baud_rate,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_tx,
  output logic               o_tx_done,
  output logic               o_busy,
  output logic               o_full,
  output logic               o_empty
);
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int SW = $clog2(SB_TICK > 16 ? SB_TICK : 16);
  localparam int NW = $clog2(NB_DATA);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [NW-1:0] n_q, n_d;
  logic [NB_DATA-1:0] sh_q, sh_d, head;
  logic par_q, par_d, tx_q, tx_d, done_q, done_d;
  logic push, pop, last;
  logic [FIFO_AW:0] wr_q, rd_q;
  logic [NB_DATA-1:0] mem [2**FIFO_AW];
  assign o_empty = wr_q == rd_q;
  assign o_full = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) && (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);
  assign push = i_tx_start && !o_full;
  assign head = mem[rd_q[FIFO_AW-1:0]];
  assign o_tx = tx_q;
  assign o_tx_done = done_q;
  assign o_busy = state_q != IDLE;
  always_ff @(posedge clk)
    if (push) mem[wr_q[FIFO_AW-1:0]] <= i_data;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      wr_q    <= wr_q + (FIFO_AW+1)'(push);
      rd_q    <= rd_q + (FIFO_AW+1)'(pop);
    end
  end
  // Every non-idle state counts 16 ticks per bit, except STOP which counts SB_TICK.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    last    = s_q == SW'(state_q == STOP ? SB_TICK - 1 : 15);
    case (state_q)
      IDLE: if (!o_empty) begin
        pop     = 1'b1;
        sh_d    = head;
        par_d   = ~^head;
        s_d     = '0;
        tx_d    = 1'b0;
        state_d = START;
      end
      default: if (i_baud_rate) begin
        s_d = last ? '0 : s_q + SW'(1);
        if (last)
          case (state_q)
            START: begin
              n_d     = '0;
              tx_d    = sh_q[0];
              state_d = DATA;
            end
            DATA: begin
              sh_d    = sh_q >> 1;
              n_d     = n_q + NW'(1);
              tx_d    = n_q == NW'(NB_DATA - 1) ? (PAR_EN ? par_q : 1'b1) : sh_q[1];
              state_d = n_q == NW'(NB_DATA - 1) ? (PAR_EN ? PARITY : STOP) : DATA;
            end
            PARITY: begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
            default: begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          endcase
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: vector table for reset/FIFO corners, tick-level line model for frames.
module tb_uart_tx;
  localparam int SB = 16;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, i_baud_rate = 1'b0, i_tx_start = 1'b0;
  logic [7:0] i_data = '0;
  logic o_tx, o_tx_done, o_busy, o_full, o_empty;
  int passed = 0, total = 0;
  logic [7:0] exp_q[$];
  bit exp_bits[$];
  logic [7:0] t3 [6];

  typedef struct {
    logic       rst, tick, start;
    logic [7:0] data;
    logic [4:0] exp;
  } vec_t;
  vec_t vecs[13];

  uart_tx dut (
    .clk(clk), .rst(rst), .i_baud_rate(i_baud_rate), .i_tx_start(i_tx_start),
    .i_data(i_data), .o_tx(o_tx), .o_tx_done(o_tx_done), .o_busy(o_busy),
    .o_full(o_full), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Expected line level for every baud tick of one frame.
  function automatic void build(input logic [7:0] d);
    exp_bits = {};
    repeat (16) exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (16) exp_bits.push_back(d[i]);
    if (PAR) repeat (16) exp_bits.push_back($countones(d) % 2 == 0);
    repeat (SB) exp_bits.push_back(1'b1);
  endfunction

  task automatic run_line(input int n, input int prob);
    bit b, in_f;
    int frames, since, dones, errs, cyc, budget;
    logic [7:0] cur;
    in_f = 0; frames = 0; since = 0; dones = 0; errs = 0; cyc = 0; cur = '0;
    budget = n * 400 * 100 / prob + 200;
    while ((frames < n || since < 2) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (o_tx_done) dones++;
      b = $urandom_range(99) < prob;
      if (!in_f) begin
        since++;
        if (frames > 0 && since == 1) check("done_pulse", {o_tx_done, o_tx}, 2'b11);
        if (!o_tx && frames < n) begin
          if (frames > 0) check("idle_gap", since, 2);
          cur = exp_q.pop_front();
          build(cur);
          in_f = 1;
          errs = 0;
        end
      end
      if (in_f && b) begin
        if (o_tx !== exp_bits.pop_front()) errs++;
        if (exp_bits.size() == 0) begin
          in_f = 0;
          frames++;
          since = 0;
          check($sformatf("frame_%02h", cur), errs, 0);
        end
      end
      i_baud_rate = b;
    end
    check("frame_count", frames, n);
    check("done_count", dones, n);
  endtask

  task automatic quiet(input int ncyc);
    int bad;
    bad = 0;
    i_baud_rate = 1'b1;
    repeat (ncyc) begin
      @(negedge clk);
      if (!o_tx || o_tx_done || o_busy) bad++;
    end
    check("quiet", bad, 0);
  endtask

  task automatic burst(input logic [7:0] bytes[$], input int prob);
    int n;
    n = bytes.size() < 5 ? bytes.size() : 5;
    i_baud_rate = 1'b0;
    foreach (bytes[k]) begin
      i_tx_start = 1'b1;
      i_data = bytes[k];
      if (k < 5) exp_q.push_back(bytes[k]);
      @(negedge clk);
    end
    i_tx_start = 1'b0;
    run_line(n, prob);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    int errs, dn;
    t3 = '{8'h3A, 8'hC4, 8'h5F, 8'h80, 8'h01, 8'h99};
    for (int i = 0; i < 5; i++) vecs[i] = '{1'b0, 1'b0, i == 2, 8'hEE, 5'b10001};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00,  5'b10001};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, t3[0], 5'b10000};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, t3[1], 5'b00100};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, t3[2], 5'b00100};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, t3[3], 5'b00100};
    vecs[10] = '{1'b1, 1'b0, 1'b1, t3[4], 5'b00110};
    vecs[11] = '{1'b1, 1'b0, 1'b1, t3[5], 5'b00110};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 8'h00,  5'b00110};
    // {o_tx, o_tx_done, o_busy, o_full, o_empty} after each edge
    for (int i = 0; i < 13; i++) begin
      rst = vecs[i].rst;
      i_baud_rate = vecs[i].tick;
      i_tx_start = vecs[i].start;
      i_data = vecs[i].data;
      @(negedge clk);
      check($sformatf("vec%0d", i), {o_tx, o_tx_done, o_busy, o_full, o_empty}, vecs[i].exp);
    end
    i_tx_start = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(t3[i]);
    run_line(5, 100);
    quiet(300);
    // 0xA5 with a tick every clock: exact per-clock waveform
    i_tx_start = 1'b1;
    i_data = 8'hA5;
    @(negedge clk);
    i_tx_start = 1'b0;
    check("push_lat", o_tx, 1'b1);
    build(8'hA5);
    errs = 0;
    dn = 0;
    foreach (exp_bits[j]) begin
      @(negedge clk);
      if (o_tx !== exp_bits[j]) errs++;
      if (o_tx_done) dn++;
    end
    check("a5_wave", errs, 0);
    check("a5_early_done", dn, 0);
    @(negedge clk);
    check("a5_done", {o_tx_done, o_busy, o_tx}, 3'b101);
    @(negedge clk);
    check("a5_done_width", o_tx_done, 1'b0);
    // reset in the middle of data bit 3 of 0x55 with two bytes queued
    i_baud_rate = 1'b0;
    q = {8'h55, 8'h11, 8'h22};
    foreach (q[k]) begin
      i_tx_start = 1'b1;
      i_data = q[k];
      @(negedge clk);
    end
    i_tx_start = 1'b0;
    i_baud_rate = 1'b1;
    repeat (70) @(negedge clk);
    check("mid_bit3", {o_tx, o_busy, o_empty}, 3'b010);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rst_mid", {o_tx, o_tx_done, o_busy, o_full, o_empty}, 5'b10001);
    quiet(400);
    q = {8'h3C, 8'hFF};
    burst(q, 100);
    q = {8'h07, 8'h03};
    burst(q, 70);
    for (int r = 0; r < 6; r++) begin
      q = {};
      repeat ($urandom_range(1, 7)) q.push_back(8'($urandom));
      burst(q, $urandom_range(40, 100));
    end
    quiet(50);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
